// File: rtl/layer_norm_stream.sv
// Streaming layer normalisation: accepts N signed elements, computes mean,
// population variance and an exact integer standard deviation, then replays
// the buffered vector as ((x - mean) << SCALE_SHIFT) / stddev, saturated.
module layer_norm_stream #(
  parameter int N           = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int ACC_WIDTH   = 32,
  parameter int SCALE_SHIFT = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic                         busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int HALF  = ACC_WIDTH / 2;
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  localparam logic signed [ACC_WIDTH-1:0] N_S      = ACC_WIDTH'(N);
  localparam logic        [ACC_WIDTH-1:0] N_U      = ACC_WIDTH'(N);
  localparam logic signed [ACC_WIDTH-1:0] ACC_ZERO = {ACC_WIDTH{1'b0}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((2 ** (DATA_WIDTH - 1)) - 1);
  // Two's complement: inverting 2^(W-1)-1 gives -2^(W-1).
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = ~SAT_MAX;
  localparam logic [IDX_W-1:0]            IDX_LAST = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0]            SQ_LAST  = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_ACCUM = 3'd0,
    S_MEAN  = 3'd1,
    S_VAR   = 3'd2,
    S_SQRT  = 3'd3,
    S_NORM  = 3'd4
  } state_t;

  // Sign-extend one element to accumulator precision.
  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
    return {{(ACC_WIDTH - DATA_WIDTH){v[DATA_WIDTH-1]}}, v};
  endfunction

  // Normalise one element; a zero deviation maps every element to zero.
  function automatic logic signed [DATA_WIDTH-1:0] norm_elem(
    input logic signed [DATA_WIDTH-1:0] x,
    input logic signed [ACC_WIDTH-1:0]  mean,
    input logic        [ACC_WIDTH-1:0]  std
  );
    logic signed [ACC_WIDTH-1:0] d;
    logic signed [ACC_WIDTH-1:0] num;
    logic signed [ACC_WIDTH-1:0] q;
    d   = sext(x) - mean;
    num = d <<< SCALE_SHIFT;
    if (std == {ACC_WIDTH{1'b0}}) begin
      q = ACC_ZERO;
    end else begin
      // std never exceeds 2^HALF-1, so reinterpreting it as signed is safe.
      q = num / $signed(std);
    end
    if (q > SAT_MAX) begin
      q = SAT_MAX;
    end else if (q < SAT_MIN) begin
      q = SAT_MIN;
    end else begin
      q = q;
    end
    return q[DATA_WIDTH-1:0];
  endfunction

  state_t                        r_state;
  state_t                        w_state_next;
  logic signed [DATA_WIDTH-1:0]  r_buf [N];
  logic signed [ACC_WIDTH-1:0]   r_sum;
  logic signed [ACC_WIDTH-1:0]   r_mean;
  logic        [ACC_WIDTH-1:0]   r_sumsq;
  // Holds the variance; the square root consumes it two bits per cycle.
  logic        [ACC_WIDTH-1:0]   r_var;
  logic        [ACC_WIDTH-1:0]   r_std;
  logic        [HALF-1:0]        r_sq_rem;
  logic        [HALF-1:0]        r_root;
  logic        [CNT_W-1:0]       r_sq_cnt;
  logic        [IDX_W-1:0]       r_idx;
  logic                          r_in_ready;
  logic                          r_out_valid;
  logic                          r_out_last;
  logic signed [DATA_WIDTH-1:0]  r_out_data;
  logic                          r_busy;

  logic                          w_in_fire;
  logic                          w_out_fire;
  logic                          w_idx_last;
  logic                          w_sq_last;
  logic        [IDX_W-1:0]       w_idx_inc;
  logic signed [ACC_WIDTH-1:0]   w_dev;
  logic        [ACC_WIDTH-1:0]   w_dev_sq;
  logic        [ACC_WIDTH-1:0]   w_sumsq_next;
  logic        [ACC_WIDTH-1:0]   w_var_final;
  logic        [HALF+1:0]        w_sq_rem_sh;
  logic        [HALF+1:0]        w_sq_trial;
  logic                          w_sq_ge;
  logic        [HALF-1:0]        w_root_next;
  logic signed [DATA_WIDTH-1:0]  w_norm_x;
  logic        [ACC_WIDTH-1:0]   w_norm_std;
  logic signed [DATA_WIDTH-1:0]  w_norm_q;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_idx_last = (r_idx == IDX_LAST);
  assign w_sq_last  = (r_sq_cnt == SQ_LAST);
  assign w_idx_inc  = r_idx + IDX_W'(1);

  // Variance step: squared deviation of the current buffered element.
  assign w_dev        = sext(r_buf[r_idx]) - r_mean;
  assign w_dev_sq     = w_dev * w_dev;
  assign w_sumsq_next = r_sumsq + w_dev_sq;
  assign w_var_final  = w_sumsq_next / N_U;

  // Restoring square root: bring down two radicand bits, try (root<<2)|1.
  assign w_sq_rem_sh  = {r_sq_rem, r_var[ACC_WIDTH-1:ACC_WIDTH-2]};
  assign w_sq_trial   = {r_root, 2'b01};
  assign w_sq_ge      = (w_sq_rem_sh >= w_sq_trial);
  assign w_root_next  = {r_root[HALF-2:0], w_sq_ge};

  // Select the element to normalise: element 0 as the root completes, else the next one.
  always_comb begin
    w_norm_x   = r_buf[0];
    w_norm_std = r_std;
    if (r_state == S_SQRT) begin
      w_norm_x   = r_buf[0];
      w_norm_std = {{(ACC_WIDTH - HALF){1'b0}}, w_root_next};
    end else begin
      w_norm_x   = r_buf[w_idx_inc];
      w_norm_std = r_std;
    end
  end

  assign w_norm_q = norm_elem(w_norm_x, r_mean, w_norm_std);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the accumulate / statistics / replay sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_ACCUM: begin
        if (w_in_fire && w_idx_last) begin
          w_state_next = S_MEAN;
        end else begin
          w_state_next = S_ACCUM;
        end
      end
      S_MEAN: begin
        w_state_next = S_VAR;
      end
      S_VAR: begin
        if (w_idx_last) begin
          w_state_next = S_SQRT;
        end else begin
          w_state_next = S_VAR;
        end
      end
      S_SQRT: begin
        if (w_sq_last) begin
          w_state_next = S_NORM;
        end else begin
          w_state_next = S_SQRT;
        end
      end
      S_NORM: begin
        if (w_out_fire && w_idx_last) begin
          w_state_next = S_ACCUM;
        end else begin
          w_state_next = S_NORM;
        end
      end
      default: begin
        w_state_next = S_ACCUM;
      end
    endcase
  end

  // Datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        r_buf[k] <= {DATA_WIDTH{1'b0}};
      end
      r_sum       <= ACC_ZERO;
      r_mean      <= ACC_ZERO;
      r_sumsq     <= {ACC_WIDTH{1'b0}};
      r_var       <= {ACC_WIDTH{1'b0}};
      r_std       <= {ACC_WIDTH{1'b0}};
      r_sq_rem    <= {HALF{1'b0}};
      r_root      <= {HALF{1'b0}};
      r_sq_cnt    <= {CNT_W{1'b0}};
      r_idx       <= {IDX_W{1'b0}};
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
      r_busy      <= 1'b0;
    end else begin
      r_busy <= (w_state_next != S_ACCUM);
      case (r_state)
        S_ACCUM: begin
          // Ready rises one cycle after reset and drops on the final accept.
          r_in_ready <= ~(w_in_fire & w_idx_last);
          if (w_in_fire) begin
            r_buf[r_idx] <= in_data;
            r_sum        <= r_sum + sext(in_data);
            r_idx        <= w_idx_last ? {IDX_W{1'b0}} : w_idx_inc;
          end
        end
        S_MEAN: begin
          // Signed division truncates toward zero.
          r_mean  <= r_sum / N_S;
          r_sumsq <= {ACC_WIDTH{1'b0}};
          r_idx   <= {IDX_W{1'b0}};
        end
        S_VAR: begin
          r_sumsq <= w_sumsq_next;
          if (w_idx_last) begin
            r_var    <= w_var_final;
            r_sq_rem <= {HALF{1'b0}};
            r_root   <= {HALF{1'b0}};
            r_sq_cnt <= {CNT_W{1'b0}};
            r_idx    <= {IDX_W{1'b0}};
          end else begin
            r_idx <= w_idx_inc;
          end
        end
        S_SQRT: begin
          r_var    <= r_var << 2;
          // Before the final step the remainder stays below 2^HALF.
          r_sq_rem <= HALF'(w_sq_ge ? (w_sq_rem_sh - w_sq_trial) : w_sq_rem_sh);
          r_root   <= w_root_next;
          r_sq_cnt <= r_sq_cnt + CNT_W'(1);
          if (w_sq_last) begin
            r_std       <= {{(ACC_WIDTH - HALF){1'b0}}, w_root_next};
            r_out_valid <= 1'b1;
            r_out_data  <= w_norm_q;
            r_out_last  <= 1'b0;
            r_idx       <= {IDX_W{1'b0}};
          end
        end
        S_NORM: begin
          if (w_out_fire) begin
            if (w_idx_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_out_data  <= {DATA_WIDTH{1'b0}};
              r_in_ready  <= 1'b1;
              r_sum       <= ACC_ZERO;
              r_idx       <= {IDX_W{1'b0}};
            end else begin
              r_idx       <= w_idx_inc;
              r_out_data  <= w_norm_q;
              r_out_last  <= (w_idx_inc == IDX_LAST);
            end
          end
        end
        default: begin
          r_idx <= {IDX_W{1'b0}};
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = r_busy;

endmodule

// File: tb/tb_layer_norm_stream.sv
// Self-checking bench for layer_norm_stream: directed vectors, stalls,
// resets mid-vector, back-to-back streaming and randomised vectors
// checked against an arithmetic reference model.
module tb_layer_norm_stream;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int AW  = 32;
  localparam int SS  = 7;
  localparam int LAT = N + 1 + AW / 2;

  typedef int vec_t [N];

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic                 out_last;
  logic                 busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  layer_norm_stream #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .SCALE_SHIFT(SS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: integer mean, population variance, exact integer sqrt.
  task automatic model(input vec_t v, output vec_t e);
    longint sum, mean, sumsq, vr, sd, d, q;
    sum = 0;
    for (int k = 0; k < N; k++) sum += v[k];
    mean = sum / N;
    sumsq = 0;
    for (int k = 0; k < N; k++) sumsq += (v[k] - mean) * (v[k] - mean);
    vr = sumsq / N;
    sd = 0;
    while ((sd + 1) * (sd + 1) <= vr) sd++;
    for (int k = 0; k < N; k++) begin
      if (sd == 0) q = 0;
      else begin
        d = (v[k] - mean) * (64'sd1 <<< SS);
        q = d / sd;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
      end
      e[k] = int'(q);
    end
  endtask

  task automatic send_vec(input vec_t v, input int nel, output int e0);
    int t;
    for (int k = 0; k < nel; k++) begin
      in_valid = 1'b1;
      in_data  = DW'(v[k]);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, t);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    e0 = cyc;
  endtask

  // stall_mode: 0 none, 1 three cycles per element, 2 random 0..2.
  task automatic recv_vec(input vec_t exp, input int e0, input int stall_mode, input string name);
    int t, ns;
    logic signed [DW-1:0] d;
    logic l;
    for (int i = 0; i < N; i++) begin
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      checks++;
      if (!out_valid) begin
        errors++;
        $display("FAIL %s_timeout: out_valid=0 at element %0d, required 1", name, i);
        return;
      end
      if (i == 0) begin
        checks++;
        if (cyc - e0 != LAT) begin
          errors++;
          $display("FAIL %s_latency: got %0d cycles, required %0d", name, cyc - e0, LAT);
        end
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_busy: got %0b, required 1", name, busy);
      end
      d = out_data;
      l = out_last;
      ns = (stall_mode == 1) ? 3 : (stall_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      for (int s = 0; s < ns; s++) begin
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== d || out_last !== l) begin
          errors++;
          $display("FAIL %s_hold: elem %0d got v=%0b d=%0d l=%0b, required v=1 d=%0d l=%0b",
                   name, i, out_valid, out_data, out_last, d, l);
        end
      end
      checks++;
      if (int'(d) != exp[i]) begin
        errors++;
        $display("FAIL %s_data: elem %0d got %0d, required %0d", name, i, d, exp[i]);
      end
      checks++;
      if (l !== (i == N - 1)) begin
        errors++;
        $display("FAIL %s_last: elem %0d got %0b, required %0b", name, i, l, (i == N - 1));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_return: in_ready=%0b out_valid=%0b busy=%0b, required 1 0 0",
               name, in_ready, out_valid, busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'sd0 ||
        out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: rdy=%0b vld=%0b data=%0d last=%0b busy=%0b, required all 0",
               name, in_ready, out_valid, out_data, out_last, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_values");
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%0b busy=%0b, required 1 0", in_ready, busy);
    end
  endtask

  task automatic test_directed();
    vec_t v, e;
    int e0;
    v = '{5, 5, 5, 5, 5, 5, 5, 5};
    e = '{0, 0, 0, 0, 0, 0, 0, 0};
    send_vec(v, N, e0); recv_vec(e, e0, 0, "const5");
    v = '{-4, -4, -4, -4, 4, 4, 4, 4};
    e = '{-128, -128, -128, -128, 127, 127, 127, 127};
    send_vec(v, N, e0); recv_vec(e, e0, 0, "pm4");
    v = '{0, 0, 0, 0, 0, 0, 0, 8};
    e = '{-64, -64, -64, -64, -64, -64, -64, 127};
    send_vec(v, N, e0); recv_vec(e, e0, 0, "spike");
  endtask

  task automatic test_stall();
    vec_t v, e;
    int e0;
    v = '{0, 0, 0, 0, 0, 0, 0, 8};
    e = '{-64, -64, -64, -64, -64, -64, -64, 127};
    send_vec(v, N, e0); recv_vec(e, e0, 1, "stall");
  endtask

  task automatic test_random();
    vec_t v, e;
    int e0, base, spread;
    for (int r = 0; r < 8; r++) begin
      base   = (r < 3) ? 0 : int'($urandom_range(0, 120)) - 60;
      spread = (r < 3) ? 128 : int'($urandom_range(1, 20));
      for (int k = 0; k < N; k++) begin
        v[k] = base + int'($urandom_range(0, 2 * spread - 1)) - spread;
        if (v[k] > 127) v[k] = 127;
        if (v[k] < -128) v[k] = -128;
      end
      model(v, e);
      send_vec(v, N, e0);
      recv_vec(e, e0, 2, "random");
    end
  endtask

  task automatic test_reset_mid_accum();
    vec_t v, e;
    int e0;
    v = '{100, -100, 90, 0, 0, 0, 0, 0};
    send_vec(v, 3, e0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_accum_values");
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 40)) - 20;
    model(v, e);
    send_vec(v, N, e0);
    recv_vec(e, e0, 0, "after_rst_accum");
  endtask

  task automatic test_reset_mid_sqrt();
    vec_t v, e;
    int e0;
    v = '{-50, 20, 33, 7, -9, 60, -1, 2};
    send_vec(v, N, e0);
    repeat (N + 6) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL sqrt_phase: busy=%0b out_valid=%0b, required 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_sqrt_values");
    @(negedge clk);
    check_reset_outputs("rst_sqrt_hold");
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_sqrt_release: in_ready=%0b, required 1", in_ready);
    end
    v = '{1, 2, 3, 4, 5, 6, 7, 8};
    e = '{-128, -128, -64, 0, 64, 127, 127, 127};
    send_vec(v, N, e0);
    recv_vec(e, e0, 0, "after_rst_sqrt");
  endtask

  task automatic test_back_to_back();
    int stream [2*N];
    int expv [2*N];
    vec_t v, e;
    int e0v [2];
    bit lat_seen [2];
    int ptr, nout;
    bit waiting, fire_in, fire_out;
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < N; k++) v[k] = int'($urandom_range(0, 60)) - 30;
      model(v, e);
      for (int k = 0; k < N; k++) begin
        stream[h*N + k] = v[k];
        expv[h*N + k]   = e[k];
      end
    end
    e0v = '{0, 0};
    lat_seen = '{1'b0, 1'b0};
    ptr = 0; nout = 0; waiting = 1'b0;
    in_valid = 1'b1; in_data = DW'(stream[0]); out_ready = 1'b1;
    for (int c = 0; c < 400 && nout < 2 * N; c++) begin
      @(negedge clk);
      if (waiting) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL b2b_ready_low: in_ready=%0b at cycle %0d, required 0", in_ready, cyc);
        end
      end
      if (out_valid && !lat_seen[nout / N]) begin
        lat_seen[nout / N] = 1'b1;
        checks++;
        if (cyc - e0v[nout / N] != LAT) begin
          errors++;
          $display("FAIL b2b_latency: got %0d cycles, required %0d", cyc - e0v[nout / N], LAT);
        end
      end
      fire_in  = in_valid && in_ready;
      fire_out = out_valid;
      if (fire_out) begin
        checks++;
        if (int'(out_data) != expv[nout] || out_last !== ((nout % N) == N - 1)) begin
          errors++;
          $display("FAIL b2b_data: out %0d got d=%0d l=%0b, required d=%0d l=%0b",
                   nout, out_data, out_last, expv[nout], ((nout % N) == N - 1));
        end
      end
      @(posedge clk); #1;
      if (fire_in) begin
        if (ptr % N == N - 1) begin
          e0v[ptr / N] = cyc;
          if (ptr / N == 0) waiting = 1'b1;
        end
        ptr++;
        if (ptr < 2 * N) in_data = DW'(stream[ptr]);
        else in_valid = 1'b0;
      end
      if (fire_out) begin
        if (nout == N - 1) waiting = 1'b0;
        nout++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (nout != 2 * N) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d outputs, required %0d", nout, 2 * N);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_mid_accum();
    test_reset_mid_sqrt();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
